// File: rtl/riscv_pkg.sv
// Shared types and encodings for the ID/EX stage: forward selects, result
// sources, branch funct3 codes and the E-register payload.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  // Everything decode hands to execute; a bubble is the all-zero value.
  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            jump;
    logic            jalr;
    logic            branch;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] imm_ext;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
  } id_ex_t;

  // Operand forwarding select; the reserved code falls back to the register value.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [1:0]      sel,
                                              input logic [XLEN-1:0] reg_val,
                                              input logic [XLEN-1:0] wb_val,
                                              input logic [XLEN-1:0] mem_val);
    logic [XLEN-1:0] v;
    v = reg_val;
    case (sel)
      FWD_WB:  v = wb_val;
      FWD_MEM: v = mem_val;
      default: v = reg_val;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode/hazard/execute signal bundle for the ID/EX stage.
// master: decode + hazard side; slave: the stage itself.
interface id_ex_stage_if;
  import riscv_pkg::*;

  logic                RegWriteD;
  logic [1:0]          ResultSrcD;
  logic                MemWriteD;
  logic                JumpD;
  logic                JalrD;
  logic                BranchD;
  logic [2:0]          ALUControlD;
  logic                ALUSrcD;
  logic [2:0]          Funct3D;
  logic [XLEN-1:0]     RD1D;
  logic [XLEN-1:0]     RD2D;
  logic [XLEN-1:0]     PCD;
  logic [XLEN-1:0]     PCPlus4D;
  logic [XLEN-1:0]     ImmExtD;
  logic [REGW-1:0]     Rs1D;
  logic [REGW-1:0]     Rs2D;
  logic [REGW-1:0]     RdD;
  logic                FlushE;
  logic [1:0]          ForwardAE;
  logic [1:0]          ForwardBE;
  logic [XLEN-1:0]     ALUResultM;
  logic [XLEN-1:0]     ResultW;

  logic                RegWriteE;
  logic                MemWriteE;
  logic [1:0]          ResultSrcE;
  logic [2:0]          ALUControlE;
  logic [REGW-1:0]     Rs1E;
  logic [REGW-1:0]     Rs2E;
  logic [REGW-1:0]     RdE;
  logic [XLEN-1:0]     SrcAE;
  logic [XLEN-1:0]     SrcBE;
  logic [XLEN-1:0]     WriteDataE;
  logic [XLEN-1:0]     PCPlus4E;
  logic [XLEN-1:0]     PCTargetE;
  logic                PCSrcE;

  modport master (
    output RegWriteD, ResultSrcD, MemWriteD, JumpD, JalrD, BranchD, ALUControlD,
           ALUSrcD, Funct3D, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
           FlushE, ForwardAE, ForwardBE, ALUResultM, ResultW,
    input  RegWriteE, MemWriteE, ResultSrcE, ALUControlE, Rs1E, Rs2E, RdE,
           SrcAE, SrcBE, WriteDataE, PCPlus4E, PCTargetE, PCSrcE
  );

  modport slave (
    input  RegWriteD, ResultSrcD, MemWriteD, JumpD, JalrD, BranchD, ALUControlD,
           ALUSrcD, Funct3D, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
           FlushE, ForwardAE, ForwardBE, ALUResultM, ResultW,
    output RegWriteE, MemWriteE, ResultSrcE, ALUControlE, Rs1E, Rs2E, RdE,
           SrcAE, SrcBE, WriteDataE, PCPlus4E, PCTargetE, PCSrcE
  );

endinterface

// File: rtl/id_ex_stage_branch_compare.sv
// Combinational branch condition evaluation on forwarded operands.
module branch_compare
  import riscv_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_taken_c
);

  // funct3 decode; 010/011 are never taken
  always_comb begin
    o_taken_c = 1'b0;
    case (i_funct3)
      BR_EQ:   o_taken_c = (i_a == i_b);
      BR_NE:   o_taken_c = (i_a != i_b);
      BR_LT:   o_taken_c = ($signed(i_a) <  $signed(i_b));
      BR_GE:   o_taken_c = ($signed(i_a) >= $signed(i_b));
      BR_LTU:  o_taken_c = (i_a <  i_b);
      BR_GEU:  o_taken_c = (i_a >= i_b);
      default: o_taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with execute-side forwarding, operand muxing,
// branch/jump resolution and redirect target generation.
// Optional statistics counters are enabled by defining EXEC_STATS_EN.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  id_ex_stage_if.slave  bus
`ifdef EXEC_STATS_EN
  ,
  output logic [31:0]   BubbleCnt,
  output logic [31:0]   RedirectCnt,
  output logic [31:0]   FwdCnt
`endif
);

  id_ex_t          w_d;
  id_ex_t          r_e;
  logic [XLEN-1:0] w_fwd_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_pc_base;
  logic [XLEN-1:0] w_pc_sum;
  logic            w_taken;
  logic            w_pcsrc;

  // Gather decode-side fields into the E payload
  always_comb begin
    w_d             = '0;
    w_d.reg_write   = bus.RegWriteD;
    w_d.result_src  = bus.ResultSrcD;
    w_d.mem_write   = bus.MemWriteD;
    w_d.jump        = bus.JumpD;
    w_d.jalr        = bus.JalrD;
    w_d.branch      = bus.BranchD;
    w_d.alu_control = bus.ALUControlD;
    w_d.alu_src     = bus.ALUSrcD;
    w_d.funct3      = bus.Funct3D;
    w_d.rd1         = bus.RD1D;
    w_d.rd2         = bus.RD2D;
    w_d.pc          = bus.PCD;
    w_d.pc_plus4    = bus.PCPlus4D;
    w_d.imm_ext     = bus.ImmExtD;
    w_d.rs1         = bus.Rs1D;
    w_d.rs2         = bus.Rs2D;
    w_d.rd          = bus.RdD;
  end

  // E register: loads every edge, flush inserts an all-zero bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e <= '0;
    end else if (bus.FlushE) begin
      r_e <= '0;
    end else begin
      r_e <= w_d;
    end
  end

  assign w_fwd_a = fwd_sel(bus.ForwardAE, r_e.rd1, bus.ResultW, bus.ALUResultM);
  assign w_fwd_b = fwd_sel(bus.ForwardBE, r_e.rd2, bus.ResultW, bus.ALUResultM);

  branch_compare u_branch_compare (
    .i_funct3  (r_e.funct3),
    .i_a       (w_fwd_a),
    .i_b       (w_fwd_b),
    .o_taken_c (w_taken)
  );

  assign w_pcsrc   = r_e.jump | (r_e.branch & w_taken);
  assign w_pc_base = r_e.jalr ? w_fwd_a : r_e.pc;
  assign w_pc_sum  = w_pc_base + r_e.imm_ext;

  assign bus.RegWriteE   = r_e.reg_write;
  assign bus.MemWriteE   = r_e.mem_write;
  assign bus.ResultSrcE  = r_e.result_src;
  assign bus.ALUControlE = r_e.alu_control;
  assign bus.Rs1E        = r_e.rs1;
  assign bus.Rs2E        = r_e.rs2;
  assign bus.RdE         = r_e.rd;
  assign bus.SrcAE       = w_fwd_a;
  assign bus.WriteDataE  = w_fwd_b;
  assign bus.SrcBE       = r_e.alu_src ? r_e.imm_ext : w_fwd_b;
  assign bus.PCPlus4E    = r_e.pc_plus4;
  assign bus.PCTargetE   = r_e.jalr ? {w_pc_sum[XLEN-1:1], 1'b0} : w_pc_sum;
  assign bus.PCSrcE      = w_pcsrc;

`ifdef EXEC_STATS_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_redirect_cnt;
  logic [31:0] r_fwd_cnt;

  // Event counters sampled at each edge, wrapping at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubble_cnt   <= '0;
      r_redirect_cnt <= '0;
      r_fwd_cnt      <= '0;
    end else begin
      if (bus.FlushE) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (w_pcsrc)    r_redirect_cnt <= r_redirect_cnt + 32'd1;
      if ((bus.ForwardAE != FWD_REG) || (bus.ForwardBE != FWD_REG))
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
    end
  end

  assign BubbleCnt   = r_bubble_cnt;
  assign RedirectCnt = r_redirect_cnt;
  assign FwdCnt      = r_fwd_cnt;
`endif

endmodule
